multicycle_ctrl: RTL

Multi-cycle control sequencer for the single-register-file datapath: fetches one instruction at a time over a request/acknowledge port and decodes it. It then drives the datapath's register addresses, `reg_write`, `alu_src`, `alu_ctrl` and `imm_op`, and owns the PC. The datapath's `eq_out` feeds back as `eq_in` for branch resolution. Supported subset is ADD, ADDI, BEQ and BNE; any other encoding traps.

---
 rtl/multicycle_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/execute sequencer for ADD, ADDI, BEQ and BNE
module multicycle_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm_op,
   output logic        alu_src,
   output logic        alu_ctrl,
   output logic        reg_write,
   input  logic        eq_in,
   output logic [31:0] pc,
   output logic [31:0] instret,
   output logic        trap
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, TRAP} state_t;

   state_t      state;
   logic [31:0] ir;
   logic        is_branch;
   logic        is_bne;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        dec_addi;
   logic        dec_add;
   logic        dec_branch;
   logic [31:0] imm_i;
   logic [31:0] imm_b;
   logic [31:0] br_target;
   logic        br_taken;

   assign opcode     = ir[6:0];
   assign funct3     = ir[14:12];
   assign funct7     = ir[31:25];
   assign dec_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign dec_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
   assign dec_branch = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
   assign imm_i      = {{20{ir[31]}}, ir[31:20]};
   assign imm_b      = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   // Decode outputs are already registered by EXEC, so branch resolution uses them directly
   assign br_taken   = is_bne ? !eq_in : eq_in;
   assign br_target  = pc + imm_op;
   assign imem_addr  = pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         instret   <= 32'd0;
         imem_req  <= 1'b0;
         reg_write <= 1'b0;
         trap      <= 1'b0;
         rs1       <= 5'd0;
         rs2       <= 5'd0;
         rd        <= 5'd0;
         imm_op    <= 32'd0;
         alu_src   <= 1'b0;
         alu_ctrl  <= 1'b0;
         ir        <= 32'd0;
         is_branch <= 1'b0;
         is_bne    <= 1'b0;
      end else begin
         reg_write <= 1'b0;
         case (state)
            IDLE: begin
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               if (dec_addi || dec_add || dec_branch) begin
                  rs1       <= ir[19:15];
                  rs2       <= ir[24:20];
                  rd        <= ir[11:7];
                  imm_op    <= dec_branch ? imm_b : (dec_addi ? imm_i : 32'd0);
                  alu_src   <= dec_addi;
                  alu_ctrl  <= dec_branch;
                  is_branch <= dec_branch;
                  is_bne    <= funct3[0];
                  state     <= EXEC;
               end else begin
                  trap  <= 1'b1;
                  state <= TRAP;
               end
            end
            EXEC: begin
               if (is_branch) begin
                  // A taken branch to a non-word-aligned target traps with the PC left intact
                  if (br_taken && br_target[1]) begin
                     trap  <= 1'b1;
                     state <= TRAP;
                  end else begin
                     pc       <= br_taken ? br_target : pc + 32'd4;
                     instret  <= instret + 32'd1;
                     imem_req <= 1'b1;
                     state    <= FETCH;
                  end
               end else begin
                  reg_write <= (rd != 5'd0);
                  state     <= WB;
               end
            end
            WB: begin
               pc       <= pc + 32'd4;
               instret  <= instret + 32'd1;
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            TRAP: begin
               imem_req <= 1'b0;
               trap     <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
